// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination lock.
package lock_pkg;

  localparam int DIGIT_W  = 2;
  localparam int CODE_LEN = 4;
  localparam int NUM_BTN  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    UNLOCKED,
    LOCKOUT
  } state_e;

  // Decoded button pulse: valid only when exactly one button fired.
  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] idx;
  } btn_dec_t;

  function automatic btn_dec_t onehot_idx(input logic [NUM_BTN-1:0] p);
    btn_dec_t r;
    r = '0;
    case (p)
      4'b0001: begin r.valid = 1'b1; r.idx = 2'd0; end
      4'b0010: begin r.valid = 1'b1; r.idx = 2'd1; end
      4'b0100: begin r.valid = 1'b1; r.idx = 2'd2; end
      4'b1000: begin r.valid = 1'b1; r.idx = 2'd3; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Four-digit combination lock driven by debounced one-shot button pulses.
module combo_lock_fsm
  import lock_pkg::*;
#(
  parameter logic [7:0] CODE           = 8'b11_10_01_00,
  parameter int         MAX_FAIL       = 3,
  parameter int         UNLOCK_CYCLES  = 100_000_000,
  parameter int         LOCKOUT_CYCLES = 500_000_000,
  parameter int         ENTRY_TIMEOUT  = 300_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_pulse,
  output logic       unlocked,
  output logic       locked_out,
  output logic       err_pulse,
  output logic [2:0] digit_count,
  output logic [1:0] fail_count
);

  localparam int MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC = (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  // Timer counts N-1 down to 0, so a timed state spans exactly N cycles.
  localparam logic [TW-1:0] LD_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LD_LOCK   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] LD_ENTRY  = TW'(ENTRY_TIMEOUT - 1);

  state_e        state;
  logic          mismatch;
  btn_dec_t      dec;
  logic          any_pulse, digit_bad, mm_next, last_digit, to_lock;
  logic [1:0]    fail_inc;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  assign dec        = onehot_idx(btn_pulse);
  assign any_pulse  = |btn_pulse;
  // Multi-hot presses count as a digit but can never match.
  assign digit_bad  = !dec.valid || (dec.idx != CODE[{digit_count[1:0], 1'b0} +: DIGIT_W]);
  assign mm_next    = mismatch | digit_bad;
  assign last_digit = (digit_count == 3'(CODE_LEN - 1));
  assign fail_inc   = (fail_count == 2'(MAX_FAIL)) ? fail_count : fail_count + 2'd1;
  assign to_lock    = (fail_inc == 2'(MAX_FAIL));

  // Timer reload: every accepted digit restarts the entry timeout, and the
  // final digit arms the unlock or lockout duration.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_ENTRY;
    case (state)
      IDLE:  tmr_load = any_pulse;
      ENTRY: begin
        if (any_pulse) begin
          if (!last_digit) begin
            tmr_load = 1'b1;
          end else if (!mm_next) begin
            tmr_load = 1'b1;
            tmr_val  = LD_UNLOCK;
          end else if (to_lock) begin
            tmr_load = 1'b1;
            tmr_val  = LD_LOCK;
          end
        end
      end
      default: ;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Lock state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mismatch    <= 1'b0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      err_pulse   <= 1'b0;
      digit_count <= '0;
      fail_count  <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (any_pulse) begin
            mismatch    <= digit_bad;
            digit_count <= 3'd1;
            state       <= ENTRY;
          end
        end
        ENTRY: begin
          // A pulse on the timeout edge still counts as a digit.
          if (any_pulse) begin
            if (last_digit) begin
              digit_count <= '0;
              mismatch    <= 1'b0;
              if (!mm_next) begin
                state      <= UNLOCKED;
                unlocked   <= 1'b1;
                fail_count <= '0;
              end else begin
                err_pulse  <= 1'b1;
                fail_count <= fail_inc;
                if (to_lock) begin
                  state      <= LOCKOUT;
                  locked_out <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              mismatch    <= mm_next;
              digit_count <= digit_count + 3'd1;
            end
          end else if (tmr_done) begin
            state       <= IDLE;
            digit_count <= '0;
            mismatch    <= 1'b0;
          end
        end
        UNLOCKED: begin
          if (tmr_done) begin
            state    <= IDLE;
            unlocked <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (tmr_done) begin
            state      <= IDLE;
            locked_out <= 1'b0;
            fail_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: directed scenarios plus random attempts, each
// cycle compared against a queue-based model of the lock rules.
module tb_combo_lock_fsm;

  localparam int U  = 10;
  localparam int L  = 20;
  localparam int T  = 50;
  localparam int MF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_pulse = '0;
  logic       unlocked, locked_out, err_pulse;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  wire  [7:0] obs = {unlocked, locked_out, err_pulse, digit_count, fail_count};

  int n_tests = 0;
  int n_fail  = 0;

  combo_lock_fsm #(
    .CODE           (8'b11_10_01_00),
    .MAX_FAIL       (MF),
    .UNLOCK_CYCLES  (U),
    .LOCKOUT_CYCLES (L),
    .ENTRY_TIMEOUT  (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_pulse   (btn_pulse),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int code_d[4] = '{0, 1, 2, 3};
  int q[$];
  int age = 0, ul_rem = 0, lk_rem = 0, fails = 0;
  bit m_err = 1'b0;

  task automatic model_step(input logic [3:0] p, input logic r);
    int d;
    bit ok;
    m_err = 1'b0;
    if (!r) begin
      q.delete(); age = 0; ul_rem = 0; lk_rem = 0; fails = 0;
    end else if (ul_rem > 0) begin
      ul_rem--;
    end else if (lk_rem > 0) begin
      lk_rem--;
      if (lk_rem == 0) fails = 0;
    end else if (p != 4'b0) begin
      d = -1;
      for (int i = 0; i < 4; i++) if (p == 4'(1 << i)) d = i;
      q.push_back(d);
      age = 0;
      if (q.size() == 4) begin
        ok = 1'b1;
        for (int k = 0; k < 4; k++) if (q[k] != code_d[k]) ok = 1'b0;
        q.delete();
        if (ok) begin
          ul_rem = U; fails = 0;
        end else begin
          m_err = 1'b1; fails++;
          if (fails == MF) lk_rem = L;
        end
      end
    end else if (q.size() > 0) begin
      age++;
      if (age == T) q.delete();
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {(ul_rem > 0), (lk_rem > 0), m_err, 3'(q.size()), 2'(fails)};
  endfunction

  // ---------------- stimulus plumbing ----------------
  // Entry bit 4 set = reset asserted for that edge.
  logic [4:0] stim[$];

  task automatic add(input logic [3:0] p, input int gap);
    stim.push_back({1'b0, p});
    for (int i = 0; i < gap; i++) stim.push_back(5'h00);
  endtask

  task automatic add_code(input int d0, input int d1, input int d2, input int d3, input int gap);
    add(4'(1 << d0), gap); add(4'(1 << d1), gap); add(4'(1 << d2), gap); add(4'(1 << d3), gap);
  endtask

  task automatic tick(input logic [3:0] p, input logic r);
    btn_pulse = p;
    rst_n     = r;
    @(posedge clk);
    model_step(p, r);
    #1;
    btn_pulse = '0;
    rst_n     = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(4'hF, 1'b0);
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", obs, 8'h00);
    end
    tick(4'h0, 1'b0);
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_correct();
    int n_ul = 0, n_err = 0;
    stim.delete();
    stim.push_back(5'h10);
    add(4'b0001, 4); add(4'b0010, 4); add(4'b0100, 4); add(4'b1000, 14);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      if (unlocked)  n_ul++;
      if (err_pulse) n_err++;
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL correct step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (n_ul != U) begin
      n_fail++; $display("FAIL correct_unlock_len: got %0d want %0d", n_ul, U);
    end
    n_tests++;
    if (n_err != 0) begin
      n_fail++; $display("FAIL correct_no_err: got %0d want 0", n_err);
    end
  endtask

  task automatic test_wrong();
    stim.delete();
    stim.push_back(5'h10);
    add_code(0, 1, 3, 3, 2);
    add(4'b0000, 4);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL wrong step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (fail_count !== 2'd1 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL wrong_final: got fail=%0d unl=%b want fail=1 unl=0", fail_count, unlocked);
    end
  endtask

  task automatic test_lockout();
    int n_lk = 0;
    stim.delete();
    stim.push_back(5'h10);
    add_code(0, 1, 3, 3, 1);
    add_code(3, 3, 3, 3, 1);
    add_code(2, 1, 0, 3, 0);
    for (int i = 0; i < 24; i++) stim.push_back({1'b0, 4'($urandom_range(0, 15))});
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      if (locked_out) n_lk++;
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL lockout step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (n_lk != L) begin
      n_fail++; $display("FAIL lockout_len: got %0d want %0d", n_lk, L);
    end
  endtask

  task automatic test_multihot_timeout();
    stim.delete();
    stim.push_back(5'h10);
    add(4'b0011, 1); add(4'b0010, 1); add(4'b0100, 1); add(4'b1000, 2);
    add(4'b0001, 1); add(4'b0010, 55);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL multihot_timeout step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    stim.delete();
    stim.push_back(5'h10);
    add_code(0, 1, 2, 3, 0);
    add(4'b0000, 3);
    stim.push_back(5'h10);
    add(4'b0000, 2);
    add(4'b0001, 1); add(4'b0010, 1);
    stim.push_back(5'h10);
    add_code(0, 1, 2, 3, 1);
    add(4'b0000, 12);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_boundary();
    // Pulse exactly on the entry-timeout edge, then a pulse on the unlock exit edge.
    stim.delete();
    stim.push_back(5'h10);
    add(4'b0001, T - 1);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL boundary_a step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    tick(4'b0010, 1'b1);
    n_tests++;
    if (digit_count !== 3'd2 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL boundary_timeout_edge: got %b want %b (dc 2)", obs, exp_vec());
    end
    stim.delete();
    add(4'b0100, 0); add(4'b1000, U - 1);
    add(4'b0001, 0);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL boundary_b step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (digit_count !== 3'd0 || unlocked !== 1'b0) begin
      n_fail++; $display("FAIL boundary_exit_edge: got dc=%0d unl=%b want dc=0 unl=0", digit_count, unlocked);
    end
    tick(4'b0001, 1'b1);
    n_tests++;
    if (digit_count !== 3'd1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL boundary_after_exit: got %b want %b (dc 1)", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int mode, gap;
    logic [3:0] p;
    stim.delete();
    stim.push_back(5'h10);
    for (int a = 0; a < 60; a++) begin
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) stim.push_back(5'h10);
      for (int k = 0; k < 4; k++) begin
        case (mode)
          0:       p = 4'(1 << code_d[k]);
          1:       p = 4'(1 << $urandom_range(0, 3));
          2:       p = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << code_d[k]);
          default: p = 4'(1 << $urandom_range(0, 3));
        endcase
        gap = $urandom_range(0, 6);
        if (mode == 3 && k == 1) begin
          add(p, $urandom_range(T - 2, T + 3));
          break;
        end
        add(p, gap);
      end
    end
    add(4'b0000, L + 2);
    foreach (stim[i]) begin
      tick(stim[i][3:0], !stim[i][4]);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random step %0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_multihot_timeout();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/combo_lock_fsm.md
Name: combo_lock_fsm

Overview:
- Consumes the one-shot press pulses produced by four debounced push-button channels, one pulse per button.
- Implements a 4-digit combination lock: each pulse is one digit (button index 0-3).
- Correct sequence asserts unlocked for a fixed time. Repeated failures force a timed lockout.
- Sits directly downstream of the debounce stage; outputs drive LEDs / seven-segment status logic.

Parameters:
- CODE, 8'b11_10_01_00, expected sequence; digit k = CODE[2k+1:2k], digit 0 entered first
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (1..3)
- UNLOCK_CYCLES, 100_000_000, cycles unlocked stays high
- LOCKOUT_CYCLES, 500_000_000, cycles lockout lasts
- ENTRY_TIMEOUT, 300_000_000, idle cycles mid-entry before the partial entry is discarded

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- btn_pulse  in  4  one-cycle press pulses from debounce stages, bit i = button i
- unlocked  out  1  high while in UNLOCKED
- locked_out  out  1  high while in LOCKOUT
- err_pulse  out  1  one-cycle pulse on each wrong code, including the one that causes lockout
- digit_count  out  3  digits entered so far in current attempt (0..3)
- fail_count  out  2  consecutive failures so far

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; timer 0; mismatch flag 0. Reset overrides everything, including mid-UNLOCK and mid-LOCKOUT.
- Valid pulse cycle: btn_pulse != 0. A cycle with more than one bit set counts as one digit with forced mismatch.
- States:
  - IDLE: digit_count=0. A valid pulse records digit 0 and compares it to CODE[1:0], setting the mismatch flag if different. Then digit_count=1, state→ENTRY, timeout timer loaded.
  - ENTRY: each valid pulse compares digit n to CODE[2n+1:2n], ORs the result into the mismatch flag, increments digit_count, and reloads the timer.
    - The pulse that completes digit 3 decides, effective the next cycle:
      - All four digits matched → UNLOCKED; fail_count=0.
      - Otherwise → err_pulse=1 for one cycle and fail_count+1. If the new fail_count == MAX_FAIL → LOCKOUT, else → IDLE.
    - digit_count returns to 0 and the mismatch flag clears on the decision.
    - No valid pulse for ENTRY_TIMEOUT consecutive cycles → IDLE, digit_count=0, fail_count unchanged, no err_pulse.
  - UNLOCKED: unlocked=1 for exactly UNLOCK_CYCLES cycles, then → IDLE. All pulses are ignored.
  - LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, then → IDLE with fail_count=0. All pulses are ignored.
- Latency: unlocked, locked_out and err_pulse are registered and assert on the cycle after the clock edge that samples the 4th pulse. digit_count updates on the cycle after each pulse.
- Timer: one shared down-counter, width $clog2 of the largest of the three cycle parameters, +1. Load is done so the state lasts exactly the parameter count.
- A pulse arriving on the same edge the ENTRY timeout expires is accepted: pulse wins, timer reloads.
- Pulses arriving on the exit edge of UNLOCKED/LOCKOUT are ignored; the first accepted pulse is one cycle later.
- fail_count saturates logically at MAX_FAIL; it never wraps.

Decomposition:
- Shared package lock_pkg:
  - state enum (IDLE, ENTRY, UNLOCKED, LOCKOUT)
  - DIGIT_W=2, CODE_LEN=4 constants
  - one-hot-to-index function for btn_pulse, returning a valid flag that is false for zero or multi-hot input
- One sub-module: cycle_timer.
  - Loadable down-counter with load value, load strobe and done flag.
  - Instanced once and shared by all three timed states.

Test Plan:
- Correct code: reset; pulse btn 0,1,2,3 spaced 5 cycles; UNLOCK_CYCLES=10 → digit_count steps 1,2,3; unlocked=1 from cycle after 4th pulse for exactly 10 cycles; fail_count=0; err_pulse never.
- Wrong code: pulses 0,1,3,3 → err_pulse one cycle after 4th pulse; fail_count=1; state IDLE; unlocked stays 0.
- Lockout: three wrong codes, LOCKOUT_CYCLES=20 → third gives err_pulse, locked_out=1 for 20 cycles; pulses during lockout ignored (digit_count stays 0); afterwards fail_count=0.
- Multi-hot and timeout: pulse 4'b0011 then 1,2,3 → treated as wrong (err_pulse, fail_count=1). With ENTRY_TIMEOUT=50, enter 2 digits then wait 50 cycles → digit_count=0, no err_pulse, fail_count unchanged.
- Reset mid-operation: rst_n low for one edge during UNLOCKED and again during ENTRY with digit_count=2 → next cycle all outputs 0, state IDLE; correct code afterwards unlocks normally.
- Boundary: pulse on the exact expiry edge of ENTRY timeout → accepted (digit_count increments). Pulse on the UNLOCKED exit edge → ignored.
